// File: rtl/pipe_stage_buf_pkg.sv
// rtl/pipe_stage_buf_pkg.sv - shared CPU pipeline constants (package cpu_pipe_pkg)
package cpu_pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam int DATA_W_DEF = 64;
  localparam int SIDE_W_DEF = 38;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h00000013;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// rtl/pipe_stage_buf_if.sv - valid/ready payload handshake between pipeline stages
interface pipe_stage_buf_if #(
  parameter int DATA_W = cpu_pipe_pkg::DATA_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_stage_buf_side.sv
// rtl/pipe_stage_buf_side.sv - pipe_side_reg: free-running sideband register, cleared only by reset
module pipe_side_reg #(
  parameter int W = cpu_pipe_pkg::SIDE_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) q <= '0;
    else      q <= d;
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - 2-entry skid pipeline buffer with stall-immune sideband
// Optional perf counters (stall_cnt, flush_cnt) under PIPE_STAGE_PERF_EN.
module pipe_stage_buf
  import cpu_pipe_pkg::*;
#(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter int                SIDE_W  = SIDE_W_DEF,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_buf_if.slave      bus,
  input  logic [SIDE_W-1:0]    side_i,
  output logic [SIDE_W-1:0]    side_o,
  output logic [1:0]           occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [15:0]          flush_cnt
`endif
);

  logic [1:0]        state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              push;
  logic              pop;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign occupancy     = state_q;

  // in_ready/out_valid are written alongside state so both stay registered copies of it
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state_q     <= ST_EMPTY;
      main_q      <= NOP_VAL;
      skid_q      <= NOP_VAL;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_q      <= bus.in_data;
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_q <= bus.in_data;
          end else if (push) begin
            skid_q     <= bus.in_data;
            state_q    <= ST_TWO;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            main_q      <= NOP_VAL;
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_q     <= skid_q;
            skid_q     <= NOP_VAL;
            state_q    <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          main_q      <= NOP_VAL;
          skid_q      <= NOP_VAL;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  pipe_side_reg #(.W(SIDE_W)) u_side (
    .clk (clk),
    .rst (rst),
    .d   (side_i),
    .q   (side_o)
  );

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid_q && !bus.out_ready) stall_cnt <= stall_cnt + 32'd1;
      if (flush)                         flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed plus random check of pipe_stage_buf against a queue model
module tb_pipe_stage_buf;

  localparam int DW = 64;
  localparam int SW = 38;
  localparam logic [DW-1:0] NOP = '0;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [SW-1:0] side_i;
  logic [SW-1:0] side_o;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt;
  logic [15:0]   flush_cnt;
`endif

  pipe_stage_buf_if #(.DATA_W(DW)) bus ();

  pipe_stage_buf #(.DATA_W(DW), .SIDE_W(SW), .NOP_VAL(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus.slave),
    .side_i    (side_i),
    .side_o    (side_o),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic [SW-1:0] exp_side;
  int unsigned   exp_stall;
  int unsigned   exp_flush;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("in_ready", 64'(bus.in_ready), 64'(q.size() != 2));
    check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    check("out_data", bus.out_data, (q.size() != 0) ? q[0] : NOP);
    check("side_o", 64'(side_o), 64'(exp_side));
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    check("flush_cnt", 64'(flush_cnt), 64'(exp_flush & 32'hFFFF));
`endif
  endtask

  // One clock: drive inputs, advance the queue model by the handshake rules, then compare
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                      input logic f, input logic rs, input logic [SW-1:0] s);
    logic can_push;
    logic can_pop;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    flush         = f;
    rst           = rs;
    side_i        = s;
    can_push = v && (q.size() < 2);
    can_pop  = r && (q.size() > 0);
    @(posedge clk);
    exp_side = rs ? s : '0;
    if (!rs) begin
      q.delete();
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (q.size() > 0 && !r) exp_stall++;
      if (f) exp_flush++;
      if (f) q.delete();
      else begin
        if (can_pop) void'(q.pop_front());
        if (can_push) q.push_back(d);
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    logic          v;
    logic          r;
    logic          f;
    logic          rs;
    logic [DW-1:0] d;
    logic          hold;

    exp_side  = '0;
    exp_stall = 0;
    exp_flush = 0;

    // reset held with a live offer
    for (int i = 0; i < 3; i++) step(1'b1, 64'hA5, 1'b1, 1'b0, 1'b0, 38'h1);
    check("reset_ready", 64'(bus.in_ready), 64'd1);

    // streaming
    step(1'b1, 64'h1, 1'b1, 1'b0, 1'b1, 38'h0);
    step(1'b1, 64'h2, 1'b1, 1'b0, 1'b1, 38'h0);
    step(1'b1, 64'h3, 1'b1, 1'b0, 1'b1, 38'h0);
    check("stream_tail", bus.out_data, 64'h3);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 38'h0);

    // stall and skid
    step(1'b1, 64'h10, 1'b0, 1'b0, 1'b1, 38'h0);
    step(1'b1, 64'h11, 1'b0, 1'b0, 1'b1, 38'h0);
    check("skid_full", 64'(occupancy), 64'd2);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 38'h0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 38'h0);
    check("skid_second", bus.out_data, 64'h11);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 38'h0);

    // flush while full, offered word must vanish
    step(1'b1, 64'h20, 1'b0, 1'b0, 1'b1, 38'h0);
    step(1'b1, 64'h21, 1'b0, 1'b0, 1'b1, 38'h0);
    step(1'b1, 64'h77, 1'b0, 1'b1, 1'b1, 38'h0);
    check("flush_empty", bus.out_data, NOP);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 38'h0);

    // sideband through stall and flush
    step(1'b1, 64'h30, 1'b0, 1'b0, 1'b1, 38'h5);
    step(1'b1, 64'h31, 1'b0, 1'b1, 1'b1, 38'h6);
    step(1'b1, 64'h32, 1'b0, 1'b0, 1'b1, 38'h7);
    check("side_last", 64'(side_o), 64'h7);

`ifdef PIPE_STAGE_PERF_EN
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 38'h0);
    step(1'b1, 64'hAB, 1'b0, 1'b0, 1'b1, 38'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 38'h0);
    step(1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 38'h0);
    step(1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 38'h0);
    check("perf_stall4", 64'(stall_cnt), 64'd4);
    check("perf_flush2", 64'(flush_cnt), 64'd2);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 38'h0);
    check("perf_stall_rst", 64'(stall_cnt), 64'd0);
    check("perf_flush_rst", 64'(flush_cnt), 64'd0);
`endif

    // random traffic; an offer refused by a full stage keeps its data
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 38'h0);
    hold = 1'b0;
    d    = '0;
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 59) != 0);
      f  = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 9) < 6);
      if (!hold) begin
        v = $urandom_range(0, 3) != 0;
        d = {$urandom, $urandom};
      end else begin
        v = 1'b1;
      end
      hold = v && (q.size() == 2) && rs && !f;
      step(v, d, r, f, rs, SW'({$urandom, $urandom}));
      hold = hold && (q.size() == 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed-field pipeline buffers between CPU stages.
- Carries an opaque DATA_W payload (control bits plus instruction) with a valid/ready handshake.
- Has a 2-entry skid so in_ready is a register, not a combinational path from out_ready.
- Also carries a SIDE_W write-back sideband that updates every cycle and ignores stall and flush. Instantiated between IF/ID, ID/EX and EX/MEM.

Parameters:
- DATA_W, 64, payload width in bits.
- SIDE_W, 38, sideband width (rd, write data, RegWrite).
- NOP_VAL, {DATA_W{1'b0}}, payload value presented when the stage is empty, flushed or in reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- flush  input  1  discard all buffered entries (branch or exception clear).
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  stage can accept this cycle; registered.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data holds a live entry.
- out_ready  input  1  downstream consumes out_data this cycle; out_ready=0 means stall.
- out_data  output  DATA_W  head payload; registered.
- side_i  input  SIDE_W  write-back sideband in.
- side_o  output  SIDE_W  sideband out.
- occupancy  output  2  number of live entries (0..2).

Behaviour:
- Storage: main register (head, drives out_data) and skid register. States: EMPTY(0), ONE(1), TWO(2); occupancy equals the state code.
- Events per edge: push = in_valid & in_ready; pop = out_valid & out_ready.
- Reset (rst=0 at edge), checked first:
  - state goes to EMPTY; out_valid=0; out_data=NOP_VAL; skid=NOP_VAL; in_ready=1; side_o=0.
  - in_ready=1 holds from the first edge after reset.
- Flush (rst=1, flush=1), next priority:
  - state goes to EMPTY; main and skid become NOP_VAL; out_valid=0; in_ready=1.
  - Any push in the same cycle is discarded.
  - A pop in the flush cycle is still counted as consumed by downstream; no special handling.
- Normal operation (rst=1, flush=0):
  - EMPTY, push: main<=in_data; go to ONE. No push: hold.
  - ONE, push & pop: main<=in_data; stay ONE.
  - ONE, push & !pop: skid<=in_data; go to TWO; in_ready<=0.
  - ONE, !push & pop: main<=NOP_VAL; go to EMPTY.
  - ONE, neither: hold (stall keeps main and out_valid unchanged).
  - TWO, pop: main<=skid; skid<=NOP_VAL; go to ONE; in_ready<=1. Push is impossible because in_ready=0.
  - TWO, !pop: hold.
- Derived outputs:
  - in_ready is registered and equals (next state != TWO).
  - out_valid is registered and equals (next state != EMPTY).
- Latency: a push at edge N makes the entry visible on out_data after edge N. Ordering is strict FIFO.
- Sideband: side_o <= side_i on every edge when rst=1, otherwise 0.
  - One cycle latency; independent of stall, flush and occupancy.
- Protocol: in_data must be held stable while in_valid=1 and in_ready=0. The stage must never drop or duplicate an entry.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, adds two outputs:
  - stall_cnt (32 bits): increments each cycle with out_valid=1 and out_ready=0.
  - flush_cnt (16 bits): increments on each flush=1 cycle.
  - Both are cleared by reset, are not cleared by flush, and wrap modulo 2^width.
- When not defined, the ports and counters are absent and the logic is identical otherwise.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2;
  - default widths DATA_W_DEF=64 and SIDE_W_DEF=38;
  - NOP instruction constant NOP_INST=32'h00000013.
- One sub-module, pipe_side_reg: the free-running reset-only SIDE_W register, reused wherever a stall-immune forward path is needed.
- The skid/FSM stays in the top module.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1, data 0xA5 -> out_valid=0, out_data=NOP_VAL, occupancy=0, side_o=0; in_ready=1 after release.
- Streaming: push 0x1,0x2,0x3 back-to-back with out_ready=1 -> out_data is 0x1,0x2,0x3 on consecutive cycles one cycle later, occupancy stays 1, in_ready stays 1.
- Stall and skid: push 0x10 then 0x11 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0x10 held. Raise out_ready -> 0x10 then 0x11 in order, no loss; in_ready returns to 1 after the first pop.
- Flush while full: occupancy=2, assert flush with in_valid=1, data 0x77 -> next cycle occupancy=0, out_valid=0, out_data=NOP_VAL; 0x77 is never output.
- Sideband under stall/flush: out_ready=0 and flush toggling, side_i=0x5,0x6,0x7 -> side_o=0x5,0x6,0x7 each one cycle later, unaffected.
- PIPE_STAGE_PERF_EN: 4 stalled cycles plus 2 flushes -> stall_cnt=4, flush_cnt=2; reset clears both to 0.
